// File: rtl/fpu_ret_pkg.sv
// Shared widths and the completion entry layout for the FPU retire collector.
package fpu_ret_pkg;

    localparam int unsigned RET_W = 14;
    localparam int unsigned RID_W = 9;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned INFO_W = RET_W - EXC_W;
    localparam int unsigned NPORT = 6;
    localparam int unsigned OFF_W = 3;

    // Bit positions of the sticky flags inside exc / fpcsr_flags.
    localparam int unsigned EXC_NX = 0;
    localparam int unsigned EXC_UF = 1;
    localparam int unsigned EXC_OF = 2;
    localparam int unsigned EXC_DZ = 3;
    localparam int unsigned EXC_NV = 4;

    typedef struct packed {
        logic [EXC_W-1:0]  exc;
        logic [INFO_W-1:0] info;
        logic [RID_W-1:0]  rid;
    } ret_entry_t;

    function automatic ret_entry_t make_entry(input logic [RET_W-1:0] word,
                                              input logic [RID_W-1:0] rid);
        ret_entry_t e;
        e.exc  = word[RET_W-1 -: EXC_W];
        e.info = word[INFO_W-1:0];
        e.rid  = rid;
        return e;
    endfunction

endpackage

// File: rtl/ret_compact6.sv
// Prefix popcount over the six completion enables: per-port write offset and total.
module ret_compact6
    import fpu_ret_pkg::*;
(
    input  logic [NPORT-1:0]       en,
    output logic [NPORT*OFF_W-1:0] offs,
    output logic [OFF_W-1:0]       total
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc  = '0;
        offs = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            offs[k*OFF_W +: OFF_W] = acc;
            acc = acc + OFF_W'(en[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/fpu_ret_collect.sv
// FPU completion collector: compacts up to six completions per cycle into a FIFO,
// drains up to two per cycle and accumulates sticky IEEE exception flags.
module fpu_ret_collect
    import fpu_ret_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORT-1:0]     u_ret_en,
    input  logic [NPORT*RET_W-1:0] u_ret,
    input  logic [NPORT*RID_W-1:0] u_rid,
    output logic                 stall,
    output logic [1:0]           out_vld,
    output logic [2*RET_W-1:0]   out_ret,
    output logic [2*RID_W-1:0]   out_rid,
    input  logic [1:0]           out_rdy,
    input  logic                 flags_clr,
    output logic [EXC_W-1:0]     fpcsr_flags,
    output logic                 overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ret_entry_t       mem_q [DEPTH];
    ret_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic             ovf_q, ovf_d;
    logic [EXC_W-1:0] flags_q, flags_d;

    logic [NPORT*OFF_W-1:0] offs;
    logic [OFF_W-1:0]       total;
    logic [CNT_W-1:0]       free_sp;
    logic [NPORT-1:0]       wr_ok;
    logic [OFF_W-1:0]       enq;
    logic [1:0]             rdy_eff;
    logic [1:0]             deq_sel;
    logic [1:0]             deq;
    logic [EXC_W-1:0]       deq_exc;
    ret_entry_t             head [2];

    ret_compact6 u_compact (
        .en    (u_ret_en),
        .offs  (offs),
        .total (total)
    );

    // A port is stored only if its compacted slot fits; higher ports drop first.
    always_comb begin
        free_sp = CNT_W'(DEPTH) - count_q;
        wr_ok   = '0;
        enq     = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            wr_ok[k] = u_ret_en[k] && (CNT_W'(offs[k*OFF_W +: OFF_W]) < free_sp);
            if (wr_ok[k]) begin
                enq = enq + OFF_W'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < 2; j++) begin
            head[j] = mem_q[rd_ptr_q + PTR_W'(j)];
        end
        out_vld[0] = (count_q != '0);
        out_vld[1] = (count_q >= CNT_W'(2));
        out_ret    = {head[1].exc, head[1].info, head[0].exc, head[0].info};
        out_rid    = {head[1].rid, head[0].rid};
    end

    // Only thermometer ready patterns retire anything.
    always_comb begin
        case (out_rdy)
            2'b01:   rdy_eff = 2'b01;
            2'b11:   rdy_eff = 2'b11;
            default: rdy_eff = 2'b00;
        endcase
        deq_sel = out_vld & rdy_eff;
        deq     = {1'b0, deq_sel[0]} + {1'b0, deq_sel[1]};
        deq_exc = ({EXC_W{deq_sel[0]}} & head[0].exc) |
                  ({EXC_W{deq_sel[1]}} & head[1].exc);
    end

    always_comb begin
        mem_d = mem_q;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (wr_ok[k]) begin
                mem_d[wr_ptr_q + PTR_W'(offs[k*OFF_W +: OFF_W])] =
                    make_entry(u_ret[k*RET_W +: RET_W], u_rid[k*RID_W +: RID_W]);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
        stall_d  = (CNT_W'(DEPTH) - count_d) < CNT_W'(NPORT);
        ovf_d    = ovf_q | (CNT_W'(total) > free_sp);
        flags_d  = (flags_clr ? '0 : flags_q) | deq_exc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign stall        = stall_q;
    assign overflow_err = ovf_q;
    assign fpcsr_flags  = flags_q;

endmodule
